// File: rtl/data_ram_responder.sv
// data_ram_responder: wait-stated word RAM answering MEM-stage data accesses with stall and address-error reporting.
module data_ram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ram_en,
  input  logic [3:0]  ram_write_en,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_write_data,
  output logic [31:0] ram_read_data,
  output logic        stall_req,
  output logic        addr_error
);
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [31:0] l_addr, l_wdata, c_addr, c_wdata;
  logic [3:0] l_we, c_we;
  logic complete, illegal;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0] mem [2**ADDR_WIDTH];
  // With no wait states the live request completes in IDLE; otherwise the latched one completes in ACCESS.
  always_comb begin
    complete = WAIT_CYCLES == 0 ? state == IDLE && ram_en : state == ACCESS;
    c_addr = WAIT_CYCLES == 0 ? ram_addr : l_addr;
    c_we = WAIT_CYCLES == 0 ? ram_write_en : l_we;
    c_wdata = WAIT_CYCLES == 0 ? ram_write_data : l_wdata;
    idx = c_addr[ADDR_WIDTH+1:2];
    illegal = c_addr[1:0] != 2'b00 || (c_addr >> (ADDR_WIDTH + 2)) != 32'd0;
    stall_req = rst_n && (state == WAIT || (state == IDLE && ram_en && WAIT_CYCLES > 0));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      l_addr <= '0;
      l_we <= '0;
      l_wdata <= '0;
      ram_read_data <= '0;
      addr_error <= 1'b0;
    end else begin
      addr_error <= complete && illegal;
      if (complete && c_we == 4'd0) ram_read_data <= illegal ? 32'd0 : mem[idx];
      case (state)
        IDLE: if (ram_en) begin
          l_addr <= ram_addr;
          l_we <= ram_write_en;
          l_wdata <= ram_write_data;
          cnt <= 4'(WAIT_CYCLES - 2);
          state <= WAIT_CYCLES == 0 ? IDLE : WAIT_CYCLES == 1 ? ACCESS : WAIT;
        end
        WAIT: begin
          state <= cnt == 4'd0 ? ACCESS : WAIT;
          cnt <= cnt == 4'd0 ? cnt : cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Array has no reset; the rst_n gate keeps an aborted zero-wait access from committing.
  always_ff @(posedge clk)
    if (complete && rst_n && !illegal)
      for (int i = 0; i < 4; i++)
        if (c_we[i]) mem[idx][8*i +: 8] <= c_wdata[8*i +: 8];
endmodule
